// File: rtl/sram_bist_pkg.sv
// rtl/sram_bist_pkg.sv - shared types and March C- element tables for the SRAM BIST controller
package sram_bist_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  typedef logic [2:0] elem_t;

  localparam int    NUM_ELEM   = 6;
  localparam int    PIPE_DEPTH = 2;
  localparam elem_t LAST_ELEM  = elem_t'(NUM_ELEM - 1);

  // One bit per element (bit index = element number).
  // E0 w0 | E1 r0 w1 | E2 r1 w0 | E3 down r0 w1 | E4 down r1 w0 | E5 r0
  localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;
  localparam logic [7:0] ELEM_TWO_OP = 8'b0001_1110;
  localparam logic [7:0] OP0_READ    = 8'b0011_1110;
  localparam logic [7:0] OP0_ONES    = 8'b0001_0100;
  localparam logic [7:0] OP1_ONES    = 8'b0000_1010;

  function automatic logic elem_down(input elem_t e);
    return ELEM_DOWN[e];
  endfunction

  function automatic logic elem_two_op(input elem_t e);
    return ELEM_TWO_OP[e];
  endfunction

  // The second op of an element is always a write.
  function automatic logic op_read(input elem_t e, input logic op);
    return op ? 1'b0 : OP0_READ[e];
  endfunction

  function automatic logic op_ones(input elem_t e, input logic op);
    return op ? OP1_ONES[e] : OP0_ONES[e];
  endfunction

endpackage

// File: rtl/sram_bist_checker.sv
// rtl/sram_bist_checker.sv - read-data pipeline, comparator and fail capture (SRAM_BIST_HALT_ON_FAIL_EN flushes on mismatch)
module sram_bist_checker
  import sram_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  rd_valid_i,
  input  logic [DATA_WIDTH-1:0] rd_exp_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [DATA_WIDTH-1:0] dout_i,
  output logic                  halt_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_data_o,
  output logic [CNT_WIDTH-1:0]  err_count_o
);

  localparam int TOP = PIPE_DEPTH - 1;

  logic [PIPE_DEPTH-1:0]                 vld_q, vld_d;
  logic [PIPE_DEPTH-1:0][DATA_WIDTH-1:0] exp_q, exp_d;
  logic [PIPE_DEPTH-1:0][ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]                 faddr_q, faddr_d;
  logic [DATA_WIDTH-1:0]                 fdata_q, fdata_d;
  logic [CNT_WIDTH-1:0]                  cnt_q, cnt_d;
  logic                                  mismatch;

  // The oldest pipeline slot lines up with dout0 two edges after the read was presented.
  assign mismatch = vld_q[TOP] && (dout_i != exp_q[TOP]);

`ifdef SRAM_BIST_HALT_ON_FAIL_EN
  assign halt_o = mismatch;
`else
  assign halt_o = 1'b0;
`endif

  assign fail_o      = fail_q;
  assign fail_addr_o = faddr_q;
  assign fail_data_o = fdata_q;
  assign err_count_o = cnt_q;

  // Shift the expected-data pipeline and fold each compare into the sticky status.
  always_comb begin
    vld_d   = {vld_q[PIPE_DEPTH-2:0], rd_valid_i};
    exp_d   = {exp_q[PIPE_DEPTH-2:0], rd_exp_i};
    adr_d   = {adr_q[PIPE_DEPTH-2:0], rd_addr_i};
    fail_d  = fail_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    cnt_d   = cnt_q;
`ifdef SRAM_BIST_HALT_ON_FAIL_EN
    if (mismatch) vld_d = '0;
`endif
    if (clr_i) begin
      fail_d  = 1'b0;
      faddr_d = '0;
      fdata_d = '0;
      cnt_d   = '0;
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        faddr_d = adr_q[TOP];
        fdata_d = dout_i;
      end
      if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Pipeline and status registers; reset discards any pending compares.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q   <= '0;
      exp_q   <= '0;
      adr_q   <= '0;
      fail_q  <= 1'b0;
      faddr_q <= '0;
      fdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      exp_q   <= exp_d;
      adr_q   <= adr_d;
      fail_q  <= fail_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_bist_ctrl.sv
// rtl/sram_bist_ctrl.sv - March C- BIST sequencer for a 1RW OpenRAM macro; SRAM_BIST_HALT_ON_FAIL_EN stops on first mismatch
module sram_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

  state_e                state_q, state_d;
  elem_t                 elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  op_q, op_d;
  logic                  drain_q, drain_d;
  logic                  csb0_q, csb0_d;
  logic                  web0_q, web0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  clr_q, clr_d;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_exp;
  logic [DATA_WIDTH-1:0] op_data;
  logic [ADDR_WIDTH-1:0] end_addr;
  elem_t                 elem_nxt;
  logic                  halt;

  assign op_data  = {DATA_WIDTH{op_ones(elem_q, op_q)}};
  assign end_addr = elem_down(elem_q) ? '0 : ADDR_MAX;
  assign elem_nxt = elem_q + 3'd1;

  // Sequencer: the access for the current counters is registered onto the pins and the counters advance.
  always_comb begin
    state_d  = state_q;
    elem_d   = elem_q;
    addr_d   = addr_q;
    op_d     = op_q;
    drain_d  = drain_q;
    csb0_d   = 1'b1;
    web0_d   = 1'b1;
    addr0_d  = addr0_q;
    din0_d   = '0;
    busy_d   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done_d   = (state_q == ST_DONE);
    clr_d    = 1'b0;
    rd_valid = 1'b0;
    rd_exp   = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          elem_d  = '0;
          addr_d  = '0;
          op_d    = 1'b0;
          clr_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!halt) begin
          csb0_d  = 1'b0;
          addr0_d = addr_q;
          if (op_read(elem_q, op_q)) begin
            rd_valid = 1'b1;
            rd_exp   = op_data;
          end else begin
            web0_d = 1'b0;
            din0_d = op_data;
          end
          if (elem_two_op(elem_q) && !op_q) begin
            op_d = 1'b1;
          end else begin
            op_d = 1'b0;
            if (addr_q == end_addr) begin
              if (elem_q == LAST_ELEM) begin
                state_d = ST_DRAIN;
                drain_d = 1'b0;
              end else begin
                elem_d = elem_nxt;
                addr_d = elem_down(elem_nxt) ? ADDR_MAX : '0;
              end
            end else begin
              addr_d = elem_down(elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
            end
          end
        end
      end
      ST_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (halt) state_d = ST_DONE;
  end

  // State, counters and registered macro/status outputs.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q <= ST_IDLE;
      elem_q  <= '0;
      addr_q  <= '0;
      op_q    <= 1'b0;
      drain_q <= 1'b0;
      csb0_q  <= 1'b1;
      web0_q  <= 1'b1;
      addr0_q <= '0;
      din0_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      drain_q <= drain_d;
      csb0_q  <= csb0_d;
      web0_q  <= web0_d;
      addr0_q <= addr0_d;
      din0_q  <= din0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
    end
  end

  assign csb0  = csb0_q;
  assign web0  = web0_q;
  assign addr0 = addr0_q;
  assign din0  = din0_q;
  assign busy  = busy_q;
  assign done  = done_q;

  sram_bist_checker #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_checker (
    .clk_i      (clk0),
    .rst_i      (rst0),
    .clr_i      (clr_q),
    .rd_valid_i (rd_valid),
    .rd_exp_i   (rd_exp),
    .rd_addr_i  (addr_q),
    .dout_i     (dout0),
    .halt_o     (halt),
    .fail_o     (fail),
    .fail_addr_o(fail_addr),
    .fail_data_o(fail_data),
    .err_count_o(err_count)
  );

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// tb/tb_sram_bist_ctrl.sv - self-checking bench for sram_bist_ctrl with a faulty-SRAM model
module tb_sram_bist_ctrl;

  localparam int DW    = 2;
  localparam int AW    = 4;
  localparam int CW    = 3;
  localparam int DEPTH = 16;
  localparam int NACC  = 10 * DEPTH;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk0 = 1'b0;
  logic          rst0 = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, fail, csb0, web0;
  logic [AW-1:0] fail_addr, addr0;
  logic [DW-1:0] fail_data, din0;
  logic [DW-1:0] dout0 = '0;
  logic [CW-1:0] err_count;

  always #5 clk0 = ~clk0;

  sram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk0(clk0), .rst0(rst0), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_data(fail_data), .err_count(err_count),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  // Fault environment: mode 0 none, 1 stuck bit at one address, 2 every read inverted.
  int            f_mode = 0;
  logic [AW-1:0] f_addr = '0;
  int            f_bit = 0;
  logic          f_val = 1'b0;
  logic [DW-1:0] ram [DEPTH];

  function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    if (f_mode == 1 && a == f_addr) r[f_bit] = f_val;
    else if (f_mode == 2) r = ~v;
    return r;
  endfunction

  // Single-port macro: captures at the edge after presentation, read data valid one edge later.
  always @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) ram[addr0] <= din0;
      else dout0 <= faulty(addr0, ram[addr0]);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } acc_t;

  acc_t          exp_acc[$];
  acc_t          obs[$];
  int            m_err, m_first;
  logic          m_fail;
  logic [AW-1:0] m_faddr;
  logic [DW-1:0] m_fdata;

  // Walk the March C- algorithm over a behavioural memory with the current fault applied.
  task automatic build_model();
    logic [DW-1:0] mem [DEPTH];
    int ops [6][2] = '{'{2, -1}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, -1}};
    exp_acc.delete();
    m_err = 0; m_first = -1; m_fail = 1'b0; m_faddr = '0; m_fdata = '0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < DEPTH; k++) begin
        int a;
        a = (e == 3 || e == 4) ? DEPTH - 1 - k : k;
        for (int o = 0; o < 2; o++) begin
          if (ops[e][o] >= 0) begin
            logic [DW-1:0] d;
            logic [DW-1:0] got;
            d = (ops[e][o] % 2 == 1) ? '1 : '0;
            if (ops[e][o] >= 2) begin
              mem[a] = d;
              exp_acc.push_back('{1'b1, AW'(a), d});
            end else begin
              got = faulty(AW'(a), mem[a]);
              exp_acc.push_back('{1'b0, AW'(a), '0});
              if (got != d) begin
                if (!m_fail) begin
                  m_fail = 1'b1; m_faddr = AW'(a); m_fdata = got; m_first = exp_acc.size() - 1;
                end
                m_err++;
              end
            end
          end
        end
      end
    end
  endtask

  // Observe the run after the accepting edge; stops at the first sampled done.
  task automatic monitor(output int done_n);
    obs.delete();
    done_n = -1;
    for (int n = 1; n <= 400 && done_n < 0; n++) begin
      @(posedge clk0);
      #1;
      if (n == 1) begin
        chk("busy_after_start", busy, 1);
        chk("first_access_csb", csb0, 0);
        chk("fail_cleared", fail, 0);
        chk("err_cleared", err_count, 0);
        chk("done_cleared", done, 0);
      end
      if (!csb0) obs.push_back('{~web0, addr0, din0});
      if (done) done_n = n;
    end
  endtask

  task automatic run(input bit hold, output int done_n);
    @(negedge clk0);
    start = 1'b1;
    @(posedge clk0);
    #1;
    if (!hold) start = 1'b0;
    monitor(done_n);
  endtask

  task automatic check_run(input string tag, input int done_n);
    int n_acc, d_exp, e_exp, bad;
    n_acc = NACC;
    d_exp = NACC + 3;
    e_exp = (m_err > CMAX) ? CMAX : m_err;
`ifdef SRAM_BIST_HALT_ON_FAIL_EN
    if (m_fail) begin
      n_acc = (m_first + 2 < NACC) ? m_first + 2 : NACC;
      d_exp = m_first + 4;
      e_exp = 1;
    end
`endif
    chk({tag, "_done_cycle"}, done_n, d_exp);
    chk({tag, "_n_access"}, obs.size(), n_acc);
    bad = 0;
    for (int i = 0; i < obs.size() && i < n_acc; i++) if (obs[i] !== exp_acc[i]) bad++;
    chk({tag, "_trace_diffs"}, bad, 0);
    chk({tag, "_fail"}, fail, m_fail);
    chk({tag, "_fail_addr"}, fail_addr, m_faddr);
    chk({tag, "_fail_data"}, fail_data, m_fdata);
    chk({tag, "_err_count"}, err_count, e_exp);
    chk({tag, "_busy_at_done"}, busy, 0);
  endtask

  typedef struct {
    int   mode;
    int   addr;
    int   bitn;
    int   val;
    logic exp_fail;
    int   exp_faddr;
    int   exp_fdata;
    int   exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int dn;
    int bad3;
    vecs[0] = '{0, 0, 0, 0, 1'b0, 0, 0, 0};
    vecs[1] = '{1, 5, 0, 1, 1'b1, 5, 1, 3};
    vecs[2] = '{1, 0, 1, 0, 1'b1, 0, 1, 2};
    vecs[3] = '{1, 15, 1, 1, 1'b1, 15, 2, 3};
    vecs[4] = '{2, 0, 0, 0, 1'b1, 0, 3, 7};

    repeat (3) @(posedge clk0);
    #1;
    chk("rst_csb0", csb0, 1);
    chk("rst_web0", web0, 1);
    chk("rst_addr0", addr0, 0);
    chk("rst_din0", din0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_fail_data", fail_data, 0);
    chk("rst_err", err_count, 0);
    @(negedge clk0);
    rst0 = 1'b0;

    // Table-driven fault scenarios.
    for (int i = 0; i < 5; i++) begin
      f_mode = vecs[i].mode;
      f_addr = AW'(vecs[i].addr);
      f_bit  = vecs[i].bitn;
      f_val  = vecs[i].val[0];
      build_model();
      run(1'b0, dn);
      check_run($sformatf("vec%0d", i), dn);
      chk($sformatf("vec%0d_tbl_fail", i), fail, vecs[i].exp_fail);
      chk($sformatf("vec%0d_tbl_faddr", i), fail_addr, vecs[i].exp_faddr);
      chk($sformatf("vec%0d_tbl_fdata", i), fail_data, vecs[i].exp_fdata);
`ifdef SRAM_BIST_HALT_ON_FAIL_EN
      chk($sformatf("vec%0d_tbl_err", i), err_count, vecs[i].exp_fail ? 1 : 0);
`else
      chk($sformatf("vec%0d_tbl_err", i), err_count, vecs[i].exp_err);
`endif
      if (i == 0) begin
        bad3 = 0;
        for (int j = 0; j < 2 * DEPTH; j++) begin
          if (80 + j >= obs.size()) bad3++;
          else if (obs[80 + j].addr != AW'(DEPTH - 1 - j / 2) || obs[80 + j].we != (j % 2 == 1)) bad3++;
        end
        chk("e3_down_sequence", bad3, 0);
      end
    end

    // Randomized stuck-at faults against the reference model.
    for (int r = 0; r < 4; r++) begin
      f_mode = 1;
      f_addr = AW'($urandom_range(0, DEPTH - 1));
      f_bit  = $urandom_range(0, DW - 1);
      f_val  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 5)) @(negedge clk0);
      build_model();
      run(1'b0, dn);
      check_run($sformatf("rand%0d", r), dn);
    end

    // Reset in the middle of a failing run, then a clean rerun.
    f_mode = 1; f_addr = '0; f_bit = 0; f_val = 1'b1;
    @(negedge clk0);
    start = 1'b1;
    @(posedge clk0);
    #1;
    start = 1'b0;
    repeat (50) @(posedge clk0);
    @(negedge clk0);
    chk("midrst_fail_before", fail, 1);
    rst0 = 1'b1;
    @(posedge clk0);
    #1;
    chk("midrst_csb0", csb0, 1);
    chk("midrst_web0", web0, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_fail", fail, 0);
    chk("midrst_err", err_count, 0);
    chk("midrst_done", done, 0);
    @(negedge clk0);
    rst0 = 1'b0;
    f_mode = 0;
    build_model();
    run(1'b0, dn);
    check_run("after_rst", dn);

    // Start held high: no restart while busy, restart from DONE clears status.
    f_mode = 1; f_addr = AW'(5); f_bit = 0; f_val = 1'b1;
    build_model();
    run(1'b1, dn);
    check_run("held", dn);
    f_mode = 0;
    build_model();
    start = 1'b0;
    monitor(dn);
    check_run("held_restart", dn);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_bist_ctrl.md
Name: sram_bist_ctrl

Overview:
March C- built-in self-test controller for a single-RW-port OpenRAM SRAM macro (clk0/csb0/web0/addr0/din0/dout0).
- Upstream: drives the macro's port-0 control, address and data pins.
- Downstream: consumes dout0 and compares it against expected data.
- Sits between the SoC test/boot logic and the macro. Reports pass/fail, first failing address and a saturating error count.

Parameters:
DATA_WIDTH, 2, SRAM word width; must match the macro.
ADDR_WIDTH, 4, SRAM address width; RAM_DEPTH = 1 << ADDR_WIDTH.
CNT_WIDTH, 16, width of the saturating error counter.

Ports:
clk0  input  1  clock; same clock as the macro's clk0.
rst0  input  1  synchronous, active-high reset.
start  input  1  level; sampled only in IDLE or DONE; launches a test.
busy  output  1  high from the cycle after start until done rises.
done  output  1  level; high after completion until the next accepted start or reset.
fail  output  1  sticky mismatch flag; cleared on accepted start or reset.
fail_addr  output  ADDR_WIDTH  address of the first mismatch.
fail_data  output  DATA_WIDTH  dout0 value captured at the first mismatch.
err_count  output  CNT_WIDTH  number of mismatching reads; saturates at all-ones.
csb0  output  1  macro chip select, active low.
web0  output  1  macro write enable, active low.
addr0  output  ADDR_WIDTH  macro address.
din0  output  DATA_WIDTH  macro write data.
dout0  input  DATA_WIDTH  macro read data.

Behaviour:
- Clocking and reset: one clock, clk0. Reset is synchronous and active-high on rst0.
- Reset values: csb0=1, web0=1, addr0=0, din0=0, busy=0, done=0, fail=0, fail_addr=0, fail_data=0, err_count=0.
- All outputs are registered on posedge clk0.
- States:
  - IDLE -> RUN on start.
  - RUN -> DRAIN after the last access of element 5.
  - DRAIN (2 cycles) -> DONE.
  - DONE -> RUN on start.
- March C- elements, one access issued per cycle, back-to-back, no bubbles (D0 = all-0 word, D1 = all-1 word):
  - E0 up: w D0
  - E1 up: r D0, w D1
  - E2 up: r D1, w D0
  - E3 down: r D0, w D1
  - E4 down: r D1, w D0
  - E5 up: r D0
- Within an element, the read and write of one address use consecutive cycles at the same address. Up order runs 0..RAM_DEPTH-1; down order runs RAM_DEPTH-1..0.
- Test length: 10*RAM_DEPTH accesses.
- Access encoding: read = csb0=0, web0=1, din0=0. Write = csb0=0, web0=0, din0=data. Idle = csb0=1, web0=1, addr0 held at last value.
- Read latency:
  - Access presented at edge k; the macro captures it at edge k+1.
  - dout0 is stable at edge k+2, and the controller samples it there.
  - Expected data and a read-valid tag travel through a 2-deep pipeline.
- Compare at edge k+2 (read-valid tags only):
  - On mismatch, err_count increments (saturating) and fail is set.
  - fail_addr and fail_data load only when fail was previously 0.
- Write data committed at negedge k+1 must be visible to a read issued at edge k+1. The macro guarantees this; the controller adds no bubble.
- Timing for start sampled at edge e (RAM_DEPTH=16):
  - busy=1 and first access at e+1.
  - Last access at e+160; last compare at e+162.
  - done=1 and busy=0 at e+163.
- DRAIN issues idle cycles only, so the final compares complete.
- start while busy: ignored.
- start in DONE: clears done, fail, err_count, fail_addr and fail_data; the test restarts.
- Reset mid-test: outputs return to reset values at that edge, and pending pipeline compares are discarded. Any read already captured by the macro is harmless.
- Address counter wraps only at element boundaries; no mid-element wrap is possible.

Optional Feature:
SRAM_BIST_HALT_ON_FAIL_EN.
- Defined: on the first mismatch the controller enters DONE at the next edge. It issues no further accesses, discards the other in-flight compare, and err_count=1.
- Undefined: the test runs to completion and counts every mismatch.

Decomposition:
- Package sram_bist_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - element index type (3 bits), per-element constant tables (direction, op count, read/write data per op)
  - NUM_ELEM=6, PIPE_DEPTH=2
- One sub-module, sram_bist_checker: 2-stage expected-data/valid pipeline, comparator, sticky fail, first-fail capture and saturating counter. The top holds the sequencer FSM and address/op counters.

Test Plan:
- Fault-free 16x2 macro, start pulse at edge e -> 160 accesses, done at e+163, fail=0, err_count=0, first access w D0 at addr 0, last access r at addr 15.
- Stuck-at-1 bit0 at addr 5 -> fail=1, fail_addr=5, fail_data=2'b01; err_count=3 (E1, E3 and E5 reads of D0); under SRAM_BIST_HALT_ON_FAIL_EN, done one cycle after the first compare and err_count=1.
- rst0 asserted at cycle 50 of the run -> next edge csb0=1, busy=0, fail=0; with rst0 low, a new start completes cleanly.
- start held high through the run -> no restart while busy; once in DONE, a new run starts and the prior fail/err_count are cleared.
- Element E3 -> addr0 sequence 15,15,14,14,...,0,0 with web0 alternating 1,0.
- Error injection on every read with CNT_WIDTH=2 -> err_count saturates at 3.
